dff_stim_gen: RTL and testbench

- Synthesizable stimulus generator for the DFF verification flow; this is the driving end of the flop check.
- It sequences a DUT reset, then drives a bounded stream of pseudo-random data bits.
- In parallel it publishes the expected flop output (exp_q/exp_valid) for an external comparator.
- Sits between the bench control (start) and the DFF under test.

---
 rtl/dff_stim_gen.sv | 141 ++++++++++++++
 tb/tb_dff_stim_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dff_stim_gen.sv
// Driving end of the DFF check: holds the DUT in reset, streams LFSR data bits,
// and publishes what an ideal flop would show one edge later (exp_q/exp_valid).
module dff_stim_gen #(
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned NUM_VECTORS = 10,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst1,
  input  logic             start,
  output logic             d_out,
  output logic             dut_rst,
  output logic             exp_q,
  output logic             exp_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    IDLE,
    RST_HOLD,
    RUN,
    DONE
  } state_e;

  localparam logic [15:0]      LFSR_MASK = 16'hB400;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0] VEC_LAST  = CNT_W'(NUM_VECTORS);

  state_e           state_q,     state_d;
  logic [15:0]      lfsr_q,      lfsr_d;
  logic             d_out_q,     d_out_d;
  logic             dut_rst_q,   dut_rst_d;
  logic             exp_q_q,     exp_q_d;
  logic             exp_valid_q, exp_valid_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [CNT_W-1:0] rst_cnt_q,   rst_cnt_d;

  // Galois right-shift step; the bit shifted out is the data bit for this vector.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path through
    // the case below leaves one unassigned and no latch can be inferred.
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    d_out_d   = d_out_q;
    dut_rst_d = dut_rst_q;
    busy_d    = busy_q;
    done_d    = done_q;
    count_d   = count_q;
    rst_cnt_d = rst_cnt_q;

    // Ideal-flop model: what q shows after this edge, from pre-edge d and reset.
    exp_q_d     = dut_rst_q ? 1'b0 : d_out_q;
    exp_valid_d = ~dut_rst_q & (state_q == RUN);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RST_HOLD;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          dut_rst_d = 1'b1;
          d_out_d   = 1'b0;
          rst_cnt_d = CNT_ONE;
          count_d   = '0;
        end
      end
      RST_HOLD: begin
        if (rst_cnt_q < RST_LAST) begin
          rst_cnt_d = rst_cnt_q + CNT_ONE;
        end else begin
          state_d   = RUN;
          dut_rst_d = 1'b0;
          d_out_d   = lfsr_q[0];
          lfsr_d    = lfsr_step(lfsr_q);
          count_d   = CNT_ONE;
        end
      end
      RUN: begin
        if (count_q < VEC_LAST) begin
          d_out_d = lfsr_q[0];
          lfsr_d  = lfsr_step(lfsr_q);
          count_d = count_q + CNT_ONE;
        end else begin
          // Last vector has been held its cycle; count keeps the run length.
          state_d = DONE;
          d_out_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, which the one-cycle expected-output latency depends on.
  always_ff @(posedge clk or posedge rst1) begin
    if (rst1) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED;
      d_out_q     <= 1'b0;
      dut_rst_q   <= 1'b1;
      exp_q_q     <= 1'b0;
      exp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
      rst_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      d_out_q     <= d_out_d;
      dut_rst_q   <= dut_rst_d;
      exp_q_q     <= exp_q_d;
      exp_valid_q <= exp_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      count_q     <= count_d;
      rst_cnt_q   <= rst_cnt_d;
    end
  end

  assign d_out     = d_out_q;
  assign dut_rst   = dut_rst_q;
  assign exp_q     = exp_q_q;
  assign exp_valid = exp_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign count     = count_q;

endmodule

// File: tb/tb_dff_stim_gen.sv
// Bench for dff_stim_gen: run-timeline reference model, a scoreboard of expected
// data bits checked against exp_q and a real DFF, plus a short-parameter instance.
module tb_dff_stim_gen;

  localparam int          RC   = 4;
  localparam int          NV   = 10;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst1 = 1'b1;
  logic       start = 1'b0;
  logic       d_out, dut_rst, exp_q, exp_valid, busy, done;
  logic [7:0] count;

  logic       start_b = 1'b0;
  logic       d_out_b, dut_rst_b, exp_q_b, exp_valid_b, busy_b, done_b;
  logic [7:0] count_b;

  logic       dff_q;

  always #5 clk = ~clk;

  dff_stim_gen #(.RST_CYCLES(RC), .NUM_VECTORS(NV), .SEED(SEED), .CNT_W(8)) u_dut (
    .clk(clk), .rst1(rst1), .start(start), .d_out(d_out), .dut_rst(dut_rst),
    .exp_q(exp_q), .exp_valid(exp_valid), .busy(busy), .done(done), .count(count)
  );

  dff_stim_gen #(.RST_CYCLES(1), .NUM_VECTORS(1), .SEED(SEED), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst1(rst1), .start(start_b), .d_out(d_out_b), .dut_rst(dut_rst_b),
    .exp_q(exp_q_b), .exp_valid(exp_valid_b), .busy(busy_b), .done(done_b), .count(count_b)
  );

  // The flop under test, reset by the generator.
  always @(posedge clk or posedge dut_rst) begin
    if (dut_rst) dff_q <= 1'b0;
    else         dff_q <= d_out;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a run is a timeline of edges since start was accepted.
  logic [15:0] m_lfsr    = SEED;
  bit          m_started = 1'b0;
  int          m_t       = 0;
  bit          m_bits[NV];
  bit          sb_q[$];

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk or posedge rst1) begin
    if (rst1) begin
      m_started = 1'b0;
      m_t       = 0;
      m_lfsr    = SEED;
      sb_q.delete();
    end else if (start && (!m_started || m_t >= RC + NV)) begin
      m_started = 1'b1;
      m_t       = 0;
      for (int i = 0; i < NV; i++) begin
        m_bits[i] = m_lfsr[0];
        sb_q.push_back(m_lfsr[0]);
        m_lfsr = lfsr_next(m_lfsr);
      end
    end else if (m_started && m_t <= RC + NV) begin
      m_t++;
    end
  end

  typedef struct packed {
    logic       rst;
    logic       d;
    logic       busy;
    logic       done;
    logic       ev;
    logic [7:0] cnt;
  } exp_t;

  function automatic exp_t model_now();
    exp_t e;
    int   t;
    e = '{rst: 1'b1, d: 1'b0, busy: 1'b0, done: 1'b0, ev: 1'b0, cnt: 8'd0};
    if (m_started) begin
      t      = m_t;
      e.rst  = (t < RC);
      e.busy = (t < RC + NV);
      e.done = !e.busy;
      e.cnt  = (t < RC) ? 8'd0 : 8'(((t - RC + 1) < NV) ? (t - RC + 1) : NV);
      e.d    = (t >= RC && t < RC + NV) ? m_bits[t - RC] : 1'b0;
      e.ev   = (t >= RC + 1 && t <= RC + NV);
    end
    return e;
  endfunction

  // Control-path checker: every cycle, all outputs against the run timeline.
  always @(negedge clk) begin : ctrl_chk
    exp_t e;
    e = model_now();
    check("dut_rst",   16'(dut_rst),   16'(e.rst));
    check("d_out",     16'(d_out),     16'(e.d));
    check("busy",      16'(busy),      16'(e.busy));
    check("done",      16'(done),      16'(e.done));
    check("count",     16'(count),     16'(e.cnt));
    check("exp_valid", 16'(exp_valid), 16'(e.ev));
    if (!e.ev) check("exp_q_idle", 16'(exp_q), 16'h0);
  end

  // Scoreboard monitor: each presented sample consumes one expected bit.
  always @(negedge clk) begin : sb_mon
    bit b;
    if (exp_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 16'(sb_q.size()), 16'h1);
      end else begin
        b = sb_q.pop_front();
        check("exp_q", 16'(exp_q), 16'(b));
        check("dff_q", 16'(dff_q), 16'(b));
      end
    end
  end

  task automatic run_prefix(input string tag);
    logic [3:0] got;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_rst_last"}, 16'(dut_rst), 16'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got[i] = d_out;
    end
    check({tag, "_prefix"}, 16'(got), 16'h0001);
  endtask

  task automatic wait_done(input string tag, output int cycles);
    bit seen = 1'b0;
    cycles = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 16'(seen), 16'h1);
    check({tag, "_count"}, 16'(count), 16'(NV));
  endtask

  initial begin
    int cyc;

    repeat (3) @(negedge clk);
    rst1 = 1'b0;
    repeat (5) @(negedge clk);

    // Short instance: one reset cycle, one vector.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b_rst_e0",  16'(dut_rst_b), 16'h1);
    check("b_busy_e0", 16'(busy_b),    16'h1);
    @(negedge clk);
    check("b_d_e1",    16'(d_out_b),     16'h1);
    check("b_rst_e1",  16'(dut_rst_b),   16'h0);
    check("b_ev_e1",   16'(exp_valid_b), 16'h0);
    check("b_cnt_e1",  16'(count_b),     16'h1);
    @(negedge clk);
    check("b_ev_e2",   16'(exp_valid_b), 16'h1);
    check("b_q_e2",    16'(exp_q_b),     16'h1);
    check("b_done_e2", 16'(done_b),      16'h1);
    check("b_busy_e2", 16'(busy_b),      16'h0);
    check("b_d_e2",    16'(d_out_b),     16'h0);
    @(negedge clk);
    check("b_ev_e3",   16'(exp_valid_b), 16'h0);

    // First run from SEED, done exactly at E14 (seven edges after E7).
    run_prefix("run1");
    wait_done("run1", cyc);
    check("run1_done_edge", 16'(cyc), 16'd7);
    repeat (3) @(negedge clk);

    // start held across a run and into DONE: relaunch from the advanced LFSR.
    start = 1'b1;
    repeat (2 * (RC + NV) + 5) @(negedge clk);
    start = 1'b0;
    wait_done("held", cyc);
    repeat (2) @(negedge clk);

    // rst1 mid-run at E7, then a fresh run replays the SEED prefix.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst1 = 1'b1;
    #1;
    check("mid_rst_dut_rst", 16'(dut_rst),   16'h1);
    check("mid_rst_ev",      16'(exp_valid), 16'h0);
    check("mid_rst_busy",    16'(busy),      16'h0);
    check("mid_rst_count",   16'(count),     16'h0);
    check("mid_rst_d",       16'(d_out),     16'h0);
    @(negedge clk);
    rst1 = 1'b0;
    @(negedge clk);
    run_prefix("after_rst");
    wait_done("after_rst", cyc);

    // Random start traffic with occasional asynchronous rst1 pulses.
    for (int c = 0; c < 400; c++) begin
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 79) == 0) begin
        #3 rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    start = 1'b0;
    repeat (RC + NV + 5) @(negedge clk);
    check("sb_drained", 16'(sb_q.size()), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
